// File: rtl/slurm32_regfile_pkg.sv
// Shared types and constants for the banked SLURM32 register file.
package slurm32_regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } seq_state_t;

    localparam int BANKS_MIN = 2;
    localparam int BANKS_MAX = 8;

    function automatic int bank_w(input int banks);
        return (banks <= 2) ? 1 : $clog2(banks);
    endfunction

endpackage

// File: rtl/slurm32_cpu_regfile_banked_if.sv
// Bank push/pop bus between the register file and its bank controller.
interface slurm32_cpu_regfile_banked_if #(
    parameter int BANK_W = 1
) ();
    logic              bank_enter;
    logic              bank_exit;
    logic              hold;
    logic [BANK_W-1:0] bank_cur;
    logic              bank_err;

    modport master (output bank_enter, output bank_exit, output hold,
                    input  bank_cur,   input  bank_err);
    modport slave  (input  bank_enter, input  bank_exit,  input  hold,
                    output bank_cur,   output bank_err);
endinterface

// File: rtl/slurm32_regfile_bank_ctrl.sv
// Interrupt bank stack pointer: push on enter, pop on exit, sticky error on over/underflow.
module slurm32_regfile_bank_ctrl
    import slurm32_regfile_pkg::*;
#(
    parameter int BANKS = 2
) (
    input  logic clk,
    input  logic rstb,
    slurm32_cpu_regfile_banked_if.slave bus
);
    localparam int BW = bank_w(BANKS);

    logic [BW-1:0] cur_reg, cur_next;
    logic          err_reg, err_next;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cur_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cur_reg <= cur_next;
            err_reg <= err_next;
        end
    end

    always_comb begin
        cur_next = cur_reg;
        err_next = err_reg;
        if (!bus.hold) begin
            if (bus.bank_enter && !bus.bank_exit) begin
                if (cur_reg == BW'(BANKS - 1)) err_next = 1'b1;
                else                           cur_next = cur_reg + 1'b1;
            end else if (bus.bank_exit && !bus.bank_enter) begin
                if (cur_reg == '0) err_next = 1'b1;
                else               cur_next = cur_reg - 1'b1;
            end
        end
    end

    assign bus.bank_cur = cur_reg;
    assign bus.bank_err = err_reg;

endmodule

// File: rtl/slurm32_cpu_regfile_banked.sv
// Banked dual-read register file with zero register, write-first forwarding
// and a power-on clear sequencer that sweeps every entry of every bank.
module slurm32_cpu_regfile_banked
    import slurm32_regfile_pkg::*;
#(
    parameter int REG_BITS = 8,
    parameter int BITS     = 32,
    parameter int BANKS    = 2
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic                       wr_en,
    input  logic [REG_BITS-1:0]        regIn_sel,
    input  logic [BITS-1:0]            regIn_data,
    input  logic [REG_BITS-1:0]        regOutA_sel,
    input  logic [REG_BITS-1:0]        regOutB_sel,
    output logic [BITS-1:0]            regOutA_data,
    output logic [BITS-1:0]            regOutB_data,
    input  logic                       bank_enter,
    input  logic                       bank_exit,
    output logic [bank_w(BANKS)-1:0]   bank_cur,
    output logic                       busy,
    output logic                       bank_err
);
    localparam int BW     = bank_w(BANKS);
    localparam int ADDR_W = BW + REG_BITS;
    localparam int DEPTH  = BANKS << REG_BITS;

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [BITS-1:0]   ram_wdata;
    logic              user_we;
    logic [BITS-1:0]   wdata_reg;

    logic [REG_BITS-1:0] rd_sel  [2];
    logic [BITS-1:0]     rd_data [2];

    slurm32_cpu_regfile_banked_if #(.BANK_W(BW)) bank_bus ();

    assign bank_bus.bank_enter = bank_enter;
    assign bank_bus.bank_exit  = bank_exit;
    assign bank_bus.hold       = busy;
    assign bank_cur            = bank_bus.bank_cur;
    assign bank_err            = bank_bus.bank_err;

    slurm32_regfile_bank_ctrl #(.BANKS(BANKS)) u_bank_ctrl (
        .clk  (CLK),
        .rstb (RSTb),
        .bus  (bank_bus.slave)
    );

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Counter addresses are {bank, index}, so the sweep is bank-major.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next   = ST_RUN;
                    clr_cnt_next = '0;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_reg == ST_CLEAR);
    assign user_we   = RSTb && wr_en && !busy;
    assign ram_we    = RSTb && (busy || wr_en);
    assign ram_waddr = busy ? clr_cnt_reg : {bank_cur, regIn_sel};
    assign ram_wdata = busy ? '0 : regIn_data;

    assign rd_sel[0]    = regOutA_sel;
    assign rd_sel[1]    = regOutB_sel;
    assign regOutA_data = rd_data[0];
    assign regOutB_data = rd_data[1];

    always_ff @(posedge CLK) begin
        wdata_reg <= regIn_data;
    end

    // One RAM copy per read port; zero/forward decisions ride alongside the
    // raw RAM output so the array itself stays a plain registered read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [BITS-1:0] mem [DEPTH];
            logic [BITS-1:0] ram_q;
            logic            zero_reg;
            logic            fwd_reg;

            always_ff @(posedge CLK) begin
                if (ram_we) mem[ram_waddr] <= ram_wdata;
                ram_q <= mem[{bank_cur, rd_sel[gi]}];
            end

            always_ff @(posedge CLK) begin
                if (!RSTb) begin
                    zero_reg <= 1'b1;
                    fwd_reg  <= 1'b0;
                end else begin
                    zero_reg <= busy || (rd_sel[gi] == '0);
                    fwd_reg  <= user_we && (regIn_sel == rd_sel[gi]);
                end
            end

            assign rd_data[gi] = zero_reg ? '0 : (fwd_reg ? wdata_reg : ram_q);
        end
    endgenerate

endmodule

// File: tb/tb_slurm32_cpu_regfile_banked.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_slurm32_cpu_regfile_banked;
    localparam int RB    = 8;
    localparam int NB    = 2;
    localparam int NREG  = 1 << RB;
    localparam int DEPTH = NB * NREG;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        wr_en;
    logic [7:0]  regIn_sel, regOutA_sel, regOutB_sel;
    logic [31:0] regIn_data, regOutA_data, regOutB_data;

    slurm32_cpu_regfile_banked_if #(.BANK_W(1)) bif ();

    slurm32_cpu_regfile_banked #(.REG_BITS(RB), .BITS(32), .BANKS(NB)) dut (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .wr_en        (wr_en),
        .regIn_sel    (regIn_sel),
        .regIn_data   (regIn_data),
        .regOutA_sel  (regOutA_sel),
        .regOutB_sel  (regOutB_sel),
        .regOutA_data (regOutA_data),
        .regOutB_data (regOutB_data),
        .bank_enter   (bif.bank_enter),
        .bank_exit    (bif.bank_exit),
        .bank_cur     (bif.bank_cur),
        .busy         (bif.hold),
        .bank_err     (bif.bank_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [31:0] model_mem [NB][NREG];
    int          m_bank;
    bit          m_err;
    int          clear_left;
    logic [31:0] exp_a, exp_b;

    task automatic cycle(input bit rst_n, input bit we, input int wsel, input logic [31:0] wdata,
                         input int asel, input int bsel, input bit ent, input bit ext);
        RSTb           = rst_n;
        wr_en          = we;
        regIn_sel      = wsel[7:0];
        regIn_data     = wdata;
        regOutA_sel    = asel[7:0];
        regOutB_sel    = bsel[7:0];
        bif.bank_enter = ent;
        bif.bank_exit  = ext;
        @(posedge CLK);
        if (!rst_n) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < NREG; r++) model_mem[b][r] = 32'h0;
            m_bank = 0; m_err = 0; clear_left = DEPTH; exp_a = 0; exp_b = 0;
        end else if (clear_left > 0) begin
            clear_left--; exp_a = 0; exp_b = 0;
        end else begin
            exp_a = (asel == 0) ? 32'h0 : (we && wsel == asel) ? wdata : model_mem[m_bank][asel];
            exp_b = (bsel == 0) ? 32'h0 : (we && wsel == bsel) ? wdata : model_mem[m_bank][bsel];
            if (we) model_mem[m_bank][wsel] = wdata;
            if (ent && !ext) begin
                if (m_bank == NB - 1) m_err = 1; else m_bank++;
            end else if (ext && !ent) begin
                if (m_bank == 0) m_err = 1; else m_bank--;
            end
        end
        @(negedge CLK);
        $display("cycle rst_n=%0d we=%0d w[%0d]=%h a=%0d->%h b=%0d->%h bank=%0d err=%0d busy=%0d",
                 rst_n, we, wsel, wdata, asel, regOutA_data, bsel, regOutB_data,
                 bif.bank_cur, bif.bank_err, bif.hold);
    endtask

    task automatic idle(input int asel, input int bsel);
        cycle(1, 0, 0, 32'h0, asel, bsel, 0, 0);
    endtask

    task automatic reset_and_clear();
        int n;
        cycle(0, 0, 0, 32'h0, 0, 0, 0, 0);
        n = 0;
        while (bif.hold === 1'b1 && n < 2000) begin
            n++;
            idle(0, 0);
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL clear_timeout: busy still %b after %0d cycles, required 0", bif.hold, n);
        end
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < 3; i++) cycle(0, 1, 5, 32'hFFFF_FFFF, 5, 5, 1, 0);
        checks++;
        if (regOutA_data !== 32'h0 || regOutB_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: A=%h B=%h required 0", regOutA_data, regOutB_data);
        end
        checks++;
        if (bif.hold !== 1'b1 || bif.bank_cur !== 1'b0 || bif.bank_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b bank=%b err=%b required 1 0 0", bif.hold, bif.bank_cur, bif.bank_err);
        end
        // Writes and bank pushes while clearing must be ignored.
        n = 0;
        while (bif.hold === 1'b1 && n < 2000) begin
            n++;
            cycle(1, 1, $urandom_range(1, 255), $urandom, $urandom_range(0, 255), $urandom_range(0, 255), 1, 0);
            checks++;
            if (regOutA_data !== 32'h0 || regOutB_data !== 32'h0) begin
                failures++;
                $display("FAIL busy_reads: A=%h B=%h required 0", regOutA_data, regOutB_data);
            end
        end
        checks++;
        if (n !== DEPTH) begin
            failures++;
            $display("FAIL busy_length: got %0d cycles required %0d", n, DEPTH);
        end
        checks++;
        if (bif.bank_cur !== 1'b0 || bif.bank_err !== 1'b0) begin
            failures++;
            $display("FAIL busy_bank_ignored: bank=%b err=%b required 0 0", bif.bank_cur, bif.bank_err);
        end
    endtask

    task automatic test_all_zero();
        int mism;
        mism = 0;
        for (int bk = 0; bk < NB; bk++) begin
            for (int r = 0; r < NREG; r++) begin
                idle(r, NREG - 1 - r);
                if (regOutA_data !== 32'h0 || regOutB_data !== 32'h0) mism++;
            end
            if (bk < NB - 1) cycle(1, 0, 0, 32'h0, 0, 0, 1, 0);
        end
        cycle(1, 0, 0, 32'h0, 0, 0, 0, 1);
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL all_zero: %0d nonzero reads, required 0", mism);
        end
    endtask

    task automatic test_write_read();
        cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(5, 0);
        checks++;
        if (regOutA_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_r5: got %h required deadbeef", regOutA_data);
        end
        cycle(1, 1, 0, 32'h1234, 0, 0, 0, 0);
        idle(0, 5);
        checks++;
        if (regOutA_data !== 32'h0 || regOutB_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_r0: A=%h B=%h required 0 deadbeef", regOutA_data, regOutB_data);
        end
        cycle(1, 1, 0, 32'h5555, 0, 0, 0, 0);
        checks++;
        if (regOutA_data !== 32'h0) begin
            failures++;
            $display("FAIL forward_r0: got %h required 0", regOutA_data);
        end
    endtask

    task automatic test_forward();
        cycle(1, 1, 7, 32'hA5A5A5A5, 5, 7, 0, 0);
        checks++;
        if (regOutB_data !== 32'hA5A5A5A5 || regOutA_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL forward_b: A=%h B=%h required deadbeef a5a5a5a5", regOutA_data, regOutB_data);
        end
        cycle(1, 1, 9, 32'h0BADF00D, 9, 9, 0, 0);
        checks++;
        if (regOutA_data !== 32'h0BADF00D || regOutB_data !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL forward_ab: A=%h B=%h required 0badf00d", regOutA_data, regOutB_data);
        end
    endtask

    task automatic test_banks();
        cycle(1, 1, 3, 32'h11, 0, 0, 0, 0);
        // Read in the push cycle still sees bank 0.
        cycle(1, 0, 0, 32'h0, 3, 0, 1, 0);
        checks++;
        if (regOutA_data !== 32'h11 || bif.bank_cur !== 1'b1) begin
            failures++;
            $display("FAIL bank_enter: A=%h bank=%b required 11 1", regOutA_data, bif.bank_cur);
        end
        cycle(1, 1, 3, 32'h22, 0, 0, 0, 0);
        idle(3, 5);
        checks++;
        if (regOutA_data !== 32'h22 || regOutB_data !== 32'h0) begin
            failures++;
            $display("FAIL bank1_read: A=%h B=%h required 22 0", regOutA_data, regOutB_data);
        end
        cycle(1, 0, 0, 32'h0, 3, 0, 0, 1);
        checks++;
        if (regOutA_data !== 32'h22 || bif.bank_cur !== 1'b0) begin
            failures++;
            $display("FAIL bank_exit: A=%h bank=%b required 22 0", regOutA_data, bif.bank_cur);
        end
        idle(3, 0);
        checks++;
        if (regOutA_data !== 32'h11) begin
            failures++;
            $display("FAIL bank0_restore: A=%h required 11", regOutA_data);
        end
    endtask

    task automatic test_bank_err();
        cycle(1, 0, 0, 32'h0, 0, 0, 0, 1);
        checks++;
        if (bif.bank_err !== 1'b1 || bif.bank_cur !== 1'b0) begin
            failures++;
            $display("FAIL underflow: err=%b bank=%b required 1 0", bif.bank_err, bif.bank_cur);
        end
        reset_and_clear();
        cycle(1, 0, 0, 32'h0, 0, 0, 1, 0);
        checks++;
        if (bif.bank_err !== 1'b0 || bif.bank_cur !== 1'b1) begin
            failures++;
            $display("FAIL first_enter: err=%b bank=%b required 0 1", bif.bank_err, bif.bank_cur);
        end
        cycle(1, 0, 0, 32'h0, 0, 0, 1, 0);
        checks++;
        if (bif.bank_err !== 1'b1 || bif.bank_cur !== 1'b1) begin
            failures++;
            $display("FAIL overflow: err=%b bank=%b required 1 1", bif.bank_err, bif.bank_cur);
        end
        cycle(1, 0, 0, 32'h0, 0, 0, 1, 1);
        checks++;
        if (bif.bank_err !== 1'b1 || bif.bank_cur !== 1'b1) begin
            failures++;
            $display("FAIL both_hi: err=%b bank=%b required 1 1", bif.bank_err, bif.bank_cur);
        end
        reset_and_clear();
        cycle(1, 0, 0, 32'h0, 0, 0, 1, 1);
        checks++;
        if (bif.bank_err !== 1'b0 || bif.bank_cur !== 1'b0) begin
            failures++;
            $display("FAIL both_lo: err=%b bank=%b required 0 0", bif.bank_err, bif.bank_cur);
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        int mism;
        cycle(1, 1, 4, 32'hCAFE, 0, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            cycle(1, 1, $urandom_range(1, 15), $urandom, 0, 0, 0, 0);
        cycle(0, 1, 6, 32'h66, 0, 0, 0, 0);
        n = 0;
        while (bif.hold === 1'b1 && n < 2000) begin
            n++;
            cycle(1, 1, $urandom_range(1, 15), $urandom, 0, 0, 0, 0);
        end
        checks++;
        if (n !== DEPTH) begin
            failures++;
            $display("FAIL midclear_length: got %0d cycles required %0d", n, DEPTH);
        end
        mism = 0;
        for (int r = 0; r < 16; r++) begin
            idle(r, 15 - r);
            if (regOutA_data !== 32'h0 || regOutB_data !== 32'h0) mism++;
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL busy_writes_lost: %0d nonzero reads, required 0", mism);
        end
    endtask

    task automatic test_random();
        int r;
        bit ent, ext;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            ent = (r == 0) || (r == 2);
            ext = (r == 1) || (r == 2);
            cycle(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 15), $urandom_range(0, 15), ent, ext);
            checks++;
            if (regOutA_data !== exp_a || regOutB_data !== exp_b) begin
                failures++;
                $display("FAIL random_data: A=%h B=%h required %h %h", regOutA_data, regOutB_data, exp_a, exp_b);
            end
            checks++;
            if (bif.bank_cur !== m_bank[0] || bif.bank_err !== m_err || bif.hold !== 1'b0) begin
                failures++;
                $display("FAIL random_ctrl: bank=%b err=%b busy=%b required %0d %0d 0",
                         bif.bank_cur, bif.bank_err, bif.hold, m_bank, m_err);
            end
        end
    endtask

    initial begin
        RSTb = 0; wr_en = 0; regIn_sel = 0; regIn_data = 0;
        regOutA_sel = 0; regOutB_sel = 0;
        bif.bank_enter = 0; bif.bank_exit = 0;
        @(negedge CLK);
        test_reset();
        test_all_zero();
        test_write_read();
        test_forward();
        test_banks();
        test_random();
        test_bank_err();
        test_reset_midclear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slurm32_cpu_regfile_banked.md
SLURM32_CPU_REGFILE_BANKED -- requirements
Module: slurm32_cpu_regfile_banked

Interface
REQ-001 SHALL have parameter REG_BITS, default 8: register index width; 2**REG_BITS registers per bank.
REQ-002 SHALL have parameter BITS, default 32: data width.
REQ-003 SHALL have parameter BANKS, default 2: number of register banks, legal range 2..8.
REQ-004 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RSTb, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port wr_en, input, 1: write enable for regIn_sel/regIn_data.
REQ-007 SHALL have port regIn_sel, input, REG_BITS: write register index.
REQ-008 SHALL have port regIn_data, input, BITS: write data.
REQ-009 SHALL have ports regOutA_sel and regOutB_sel, input, REG_BITS each: read indices.
REQ-010 SHALL have ports regOutA_data and regOutB_data, output, BITS each: registered read data.
REQ-011 SHALL have port bank_enter, input, 1: interrupt entry; push to next bank.
REQ-012 SHALL have port bank_exit, input, 1: interrupt return; pop to previous bank.
REQ-013 SHALL have port bank_cur, output, clog2(BANKS): active bank index.
REQ-014 SHALL have port busy, output, 1: clear sequence in progress.
REQ-015 SHALL have port bank_err, output, 1: sticky bank over/underflow flag.

Function
REQ-016 Read latency SHALL be 1 cycle: outputs reflect the selected register of bank_cur as sampled at the edge.
REQ-017 Index 0 SHALL read as zero in every bank, regardless of writes.
REQ-018 Writes SHALL occur only when wr_en=1 and busy=0, into bank_cur at regIn_sel; writes to index 0 are permitted but never visible.
REQ-019 Read-during-write to the same index and bank SHALL forward the new data (write-first) on either port.
REQ-020 bank_enter alone SHALL increment bank_cur; at BANKS-1 it SHALL hold bank_cur and set bank_err.
REQ-021 bank_exit alone SHALL decrement bank_cur; at 0 it SHALL hold bank_cur and set bank_err.
REQ-022 bank_enter and bank_exit asserted together SHALL leave bank_cur and bank_err unchanged.
REQ-023 Reads and writes in the cycle of a bank change SHALL use the pre-change bank; the new bank takes effect on the next cycle.
REQ-024 Clear sequencer states SHALL be CLEAR and RUN; CLEAR writes zero to one entry per cycle, bank-major, over all BANKS*2**REG_BITS entries.
REQ-025 CLEAR->RUN SHALL occur after the last entry is written; busy SHALL drop in the same cycle that RUN is entered.
REQ-026 While busy=1: read outputs SHALL be zero; bank_enter and bank_exit SHALL be ignored.

Reset
REQ-027 RSTb=0 at an edge SHALL force regOutA_data=0, regOutB_data=0, bank_cur=0, bank_err=0, busy=1, sequencer=CLEAR, clear counter=0.
REQ-028 Reset asserted mid-clear or mid-operation SHALL restart the full clear sequence from entry 0.
REQ-029 The first clear write SHALL occur on the first edge with RSTb=1; busy SHALL deassert exactly BANKS*2**REG_BITS cycles later.

Structure
REQ-030 Package slurm32_regfile_pkg SHALL hold sequencer state encoding, the BANKS legal-range constants, and the bank-index width function.
REQ-031 Sub-module slurm32_regfile_bank_ctrl SHALL implement the bank_cur/bank_err push-pop logic.
REQ-032 Storage SHALL be one array per read port, each written identically, to allow dual-read block-RAM inference.

Verification
REQ-033 Release reset with defaults -> busy=1 for exactly 512 cycles, then 0; every register reads 0 in both banks.
REQ-034 Write r5=0xDEADBEEF in bank 0; read A=5 next cycle -> 0xDEADBEEF; write r0=0x1234 and read A=0 -> 0.
REQ-035 Same-cycle write r7=0xA5A5A5A5 with read B=7 -> regOutB_data=0xA5A5A5A5 one cycle later.
REQ-036 Write r3=0x11 in bank 0, bank_enter, write r3=0x22, read r3 -> 0x22; bank_exit, read r3 -> 0x11.
REQ-037 bank_exit at bank 0 -> bank_err=1, bank_cur=0; bank_enter twice with BANKS=2 -> bank_cur=1, bank_err=1; both asserted together -> no change.
REQ-038 Assert RSTb=0 at clear cycle 200 for one cycle -> busy stays 1 for a further 512 cycles; wr_en writes during busy are lost.
